// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: defaults, FSM states and
// the bundle of datapath registers carried between clock edges.
package uart_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT    = 8'hA5;
  localparam int unsigned TIMEOUT_CLKS_DEFAULT = 5_000_000;

  // Frame parser states, in protocol order.
  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_ADDR_HI,
    LDR_ADDR_LO,
    LDR_LEN_HI,
    LDR_LEN_LO,
    LDR_DATA_HI,
    LDR_DATA_LO,
    LDR_CHECK
  } ldr_state_t;

  // Registered datapath and outputs; one struct so reset and update stay in step.
  typedef struct packed {
    logic [15:0] base;
    logic [15:0] count;
    logic [15:0] idx;
    logic [7:0]  hi;
    logic [7:0]  chk;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;
  } ldr_regs_t;

endpackage

// File: rtl/uart_loader_byte_strobe.sv
// Turns the level-style data_ready of uart_rx (baud-clock domain) into a
// single-clk strobe in the clk domain: 2-flop synchroniser, then a registered
// rising-edge detect. The strobe appears 3 clk after the rising edge of level.
module uart_loader_byte_strobe (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic strobe
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronise, remember the previous synchronised value, register the edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples its pre-edge input;
    // blocking here would collapse the synchroniser chain into one stage.
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync1  <= level;
      sync2  <= sync1;
      prev   <= sync2;
      strobe <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Framed program loader: SYNC, big-endian base address, big-endian word count,
// payload words (hi byte first), XOR checksum. Each assembled word is written
// through a single-cycle write port. busy stalls the CPU during a load.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

  logic       strobe;
  ldr_state_t state_q, state_d;
  ldr_regs_t  r_q, r_d;
  logic [TW-1:0] timer_q, timer_d;

  uart_loader_byte_strobe u_strobe (
    .clk    (clk),
    .rst    (rst),
    .level  (rx_ready),
    .strobe (strobe)
  );

  // State, datapath and timeout registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LDR_IDLE;
      r_q     <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and datapath: advance on byte strobe, otherwise watch the timer.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    state_d  = state_q;
    r_d      = r_q;
    r_d.mem_we = 1'b0;
    timer_d  = (state_q == LDR_IDLE) ? '0 : timer_q + TW'(1);

    if (strobe) begin
      timer_d = '0;
      // Every byte after SYNC and before the checksum byte feeds the XOR.
      if (state_q != LDR_IDLE && state_q != LDR_CHECK) begin
        r_d.chk = r_q.chk ^ rx_data;
      end
      case (state_q)
        LDR_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d   = LDR_ADDR_HI;
            r_d.busy  = 1'b1;
            r_d.done  = 1'b0;
            r_d.error = 1'b0;
            r_d.chk   = 8'h00;
          end
        end
        LDR_ADDR_HI: begin
          r_d.base[15:8] = rx_data;
          state_d        = LDR_ADDR_LO;
        end
        LDR_ADDR_LO: begin
          r_d.base[7:0] = rx_data;
          state_d       = LDR_LEN_HI;
        end
        LDR_LEN_HI: begin
          r_d.count[15:8] = rx_data;
          state_d         = LDR_LEN_LO;
        end
        LDR_LEN_LO: begin
          r_d.count[7:0] = rx_data;
          r_d.idx        = 16'h0000;
          state_d        = ({r_q.count[15:8], rx_data} == 16'h0000) ? LDR_CHECK : LDR_DATA_HI;
        end
        LDR_DATA_HI: begin
          r_d.hi  = rx_data;
          state_d = LDR_DATA_LO;
        end
        LDR_DATA_LO: begin
          // Address wraps naturally in 16 bits; count of 16'hFFFF ends at idx 16'hFFFF.
          r_d.mem_we    = 1'b1;
          r_d.mem_addr  = r_q.base + r_q.idx;
          r_d.mem_wdata = {r_q.hi, rx_data};
          r_d.idx       = r_q.idx + 16'd1;
          state_d       = (r_q.idx + 16'd1 == r_q.count) ? LDR_CHECK : LDR_DATA_HI;
        end
        LDR_CHECK: begin
          // Writes already issued stay in memory; the flag only grades the frame.
          if (rx_data == r_q.chk) r_d.done  = 1'b1;
          else                    r_d.error = 1'b1;
          r_d.busy = 1'b0;
          state_d  = LDR_IDLE;
        end
      endcase
    end else if (state_q != LDR_IDLE && timer_q == TIMER_LAST) begin
      // Gap between bytes too long: abandon the frame.
      r_d.error = 1'b1;
      r_d.busy  = 1'b0;
      state_d   = LDR_IDLE;
      timer_d   = '0;
    end
  end

  assign mem_addr  = r_q.mem_addr;
  assign mem_wdata = r_q.mem_wdata;
  assign mem_we    = r_q.mem_we;
  assign busy      = r_q.busy;
  assign done      = r_q.done;
  assign error     = r_q.error;

endmodule
